line_buffer_scanout: RTL

- Read side of the draw line buffer: fetches 72-bit words (8 x 9-bit pixels) and serialises them, one pixel per cycle, into a valid/ready stream toward palette lookup / video out.
- Clears each word to zero after reading, so the buffer is empty for the next line's draw pass.
- Word address = lb_x[11:3] as written by the draw side.
- Lane i occupies bits [9i+8:9i]; lane 0 is the leftmost pixel.

---
 rtl/line_buffer_scanout_if.sv | 37 +++
 rtl/line_buffer_scanout.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/line_buffer_scanout_if.sv
// Scanout bus: line buffer read/clear port plus the outgoing pixel stream.
// master = scanout engine, slave = line buffer RAM / downstream video side.
interface line_buffer_scanout_if #(
    parameter int PIX_W = 9
);
    logic                 line_start;
    logic                 lb_rd_en;
    logic [8:0]           lb_rd_addr;
    logic [8*PIX_W-1:0]   lb_rd_data;
    logic                 lb_clr_en;
    logic [8:0]           lb_clr_addr;
    logic [PIX_W-1:0]     pixel;
    logic                 pixel_valid;
    logic                 pixel_ready;
    logic                 line_done;
    logic                 overrun;

    modport master (
        input  line_start,
        output lb_rd_en, lb_rd_addr,
        input  lb_rd_data,
        output lb_clr_en, lb_clr_addr,
        output pixel, pixel_valid,
        input  pixel_ready,
        output line_done, overrun
    );

    modport slave (
        output line_start,
        input  lb_rd_en, lb_rd_addr,
        output lb_rd_data,
        input  lb_clr_en, lb_clr_addr,
        input  pixel, pixel_valid,
        output pixel_ready,
        input  line_done, overrun
    );
endinterface

// File: rtl/line_buffer_scanout.sv
// Line buffer read side: fetches 8-pixel words, clears them behind the read,
// and serialises one pixel per cycle onto a valid/ready stream.
// Storage: 2-entry word FIFO feeding an output shifter (word + lane index).
module line_buffer_scanout #(
    parameter int LINE_WORDS = 80,
    parameter int PIX_W      = 9
) (
    input  logic                   clk_pix,
    input  logic                   rst_pix,
    line_buffer_scanout_if.master  bus
);
    localparam int         WORD_W   = 8 * PIX_W;
    localparam logic [9:0] END_ADDR = 10'(LINE_WORDS);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [9:0]        fetch_addr;
    logic [WORD_W-1:0] fifo_q [2];
    logic              fifo_rp, fifo_wp;
    logic [1:0]        fifo_cnt;
    logic [WORD_W-1:0] sh_word;
    logic [2:0]        sh_idx;

    logic              accept, ret, sh_free, issue, last;
    logic [2:0]        occ;
    logic              fifo_push, fifo_pop;
    logic [WORD_W-1:0] sh_word_nx;
    logic [2:0]        sh_idx_nx;
    logic              sh_vld_nx;
    logic [PIX_W-1:0]  pixel_nx;

    // Read data is on the bus exactly while the delayed clear strobe is high,
    // so lb_clr_en doubles as "return data valid this cycle".
    assign ret     = bus.lb_clr_en;
    assign accept  = bus.pixel_valid && bus.pixel_ready;
    assign sh_free = !bus.pixel_valid || (accept && sh_idx == 3'd7);
    // Words owned by the FIFO or still on their way back from the RAM.
    assign occ     = {1'b0, fifo_cnt} + {2'b00, bus.lb_rd_en} + {2'b00, bus.lb_clr_en};

    // FSM state register
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) state <= IDLE;
        else         state <= state_nx;
    end

    // FSM next state: a line runs from line_start until its last pixel is accepted
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.line_start) state_nx = RUN;
            RUN:     if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: read issue and end-of-line detection
    always_comb begin
        issue = 1'b0;
        last  = 1'b0;
        case (state)
            IDLE: issue = bus.line_start;
            RUN: begin
                issue = (occ < 3'd2) && (fetch_addr < END_ADDR);
                last  = accept && (sh_idx == 3'd7) && (fetch_addr == END_ADDR) &&
                        (fifo_cnt == 2'd0) && !bus.lb_rd_en && !bus.lb_clr_en;
            end
            default: ;
        endcase
    end

    // Shifter next state: FIFO head has priority over returning data to keep order
    always_comb begin
        sh_word_nx = sh_word;
        sh_idx_nx  = sh_idx;
        sh_vld_nx  = bus.pixel_valid;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        if (accept) sh_idx_nx = sh_idx + 3'd1;
        if (sh_free) begin
            sh_idx_nx = 3'd0;
            if (fifo_cnt != 2'd0) begin
                sh_word_nx = fifo_q[fifo_rp];
                sh_vld_nx  = 1'b1;
                fifo_pop   = 1'b1;
                fifo_push  = ret;
            end else if (ret) begin
                sh_word_nx = bus.lb_rd_data;
                sh_vld_nx  = 1'b1;
            end else begin
                sh_vld_nx  = 1'b0;
            end
        end else begin
            fifo_push = ret;
        end
        pixel_nx = sh_vld_nx ? sh_word_nx[sh_idx_nx*PIX_W +: PIX_W] : '0;
    end

    // Fetch side: read strobe, clear one cycle behind it, and the word FIFO
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            bus.lb_rd_en    <= 1'b0;
            bus.lb_rd_addr  <= '0;
            bus.lb_clr_en   <= 1'b0;
            bus.lb_clr_addr <= '0;
            fetch_addr      <= '0;
            fifo_q[0]       <= '0;
            fifo_q[1]       <= '0;
            fifo_rp         <= 1'b0;
            fifo_wp         <= 1'b0;
            fifo_cnt        <= '0;
        end else begin
            bus.lb_rd_en  <= issue;
            if (issue) bus.lb_rd_addr <= fetch_addr[8:0];
            bus.lb_clr_en <= bus.lb_rd_en;
            if (bus.lb_rd_en) bus.lb_clr_addr <= bus.lb_rd_addr;
            if (last)       fetch_addr <= '0;
            else if (issue) fetch_addr <= fetch_addr + 10'd1;
            if (fifo_push) begin
                fifo_q[fifo_wp] <= bus.lb_rd_data;
                fifo_wp         <= ~fifo_wp;
            end
            if (fifo_pop) fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // Output side: shifter registers, registered pixel stream and status pulses
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sh_word         <= '0;
            sh_idx          <= '0;
            bus.pixel_valid <= 1'b0;
            bus.pixel       <= '0;
            bus.line_done   <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            sh_word         <= sh_word_nx;
            sh_idx          <= sh_idx_nx;
            bus.pixel_valid <= sh_vld_nx;
            bus.pixel       <= pixel_nx;
            bus.line_done   <= last;
            bus.overrun     <= bus.line_start && (state == RUN);
        end
    end
endmodule
